// File: rtl/ex_mem_skid_stage_pkg.sv
// ex_mem_skid_stage_pkg
//   Shared definitions for the EX->MEM skid stage: default widths, NOP
//   payload values used by empty slots, and the occupancy state type.
package ex_mem_skid_stage_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;

    // Contents held by an invalid slot: write to x0 with nothing enabled.
    localparam int unsigned NOP_REG_ADDR = 0;
    localparam int unsigned ZERO_WORD    = 0;
    localparam logic        WR_DISABLE   = 1'b0;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_state_e;

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// ex_mem_skid_stage_if
//   Valid/ready writeback bus carrying NUM_LANES packets per beat.
//   valid  : producer presents a beat
//   ready  : consumer accepts the beat
//   waddr  : lane i at [i*ADDR_W +: ADDR_W]
//   we     : per-lane write enable
//   wdata  : lane i at [i*DATA_W +: DATA_W]
interface ex_mem_skid_stage_if
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_LANES = 1
);

    logic                          valid;
    logic                          ready;
    logic [NUM_LANES*ADDR_W-1:0]   waddr;
    logic [NUM_LANES-1:0]          we;
    logic [NUM_LANES*DATA_W-1:0]   wdata;

    modport master (output valid, output waddr, output we, output wdata, input ready);
    modport slave  (input valid, input waddr, input we, input wdata, output ready);

endinterface

// File: rtl/ex_mem_skid_stage_pipe_wb_slot.sv
// pipe_wb_slot
//   One valid bit plus a writeback payload register.
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture d_* and mark valid
//   clear        : return to NOP contents and invalid (wins over load)
//   d_waddr/d_we/d_wdata : payload to capture
//   valid, q_waddr/q_we/q_wdata : stored state
module pipe_wb_slot
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_LANES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        clear,
    input  logic [NUM_LANES*ADDR_W-1:0] d_waddr,
    input  logic [NUM_LANES-1:0]        d_we,
    input  logic [NUM_LANES*DATA_W-1:0] d_wdata,
    output logic                        valid,
    output logic [NUM_LANES*ADDR_W-1:0] q_waddr,
    output logic [NUM_LANES-1:0]        q_we,
    output logic [NUM_LANES*DATA_W-1:0] q_wdata
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid   <= 1'b0;
            q_waddr <= {NUM_LANES{ADDR_W'(NOP_REG_ADDR)}};
            q_we    <= {NUM_LANES{WR_DISABLE}};
            q_wdata <= {NUM_LANES{DATA_W'(ZERO_WORD)}};
        end else if (load) begin
            valid   <= 1'b1;
            q_waddr <= d_waddr;
            q_we    <= d_we;
            q_wdata <= d_wdata;
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage
//   Elastic EX->MEM pipeline register with a 2-entry skid buffer.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard all resident beats and any beat offered this cycle
//   in_bus     : slave side from EX (in_bus.ready is registered)
//   out_bus    : master side to MEM (head beat; we forced 0 when not valid)
//   stall_cnt  : saturating count of cycles with out valid and not ready
module ex_mem_skid_stage
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_LANES = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    ex_mem_skid_stage_if.slave   in_bus,
    ex_mem_skid_stage_if.master  out_bus,
    output logic [CNT_W-1:0]     stall_cnt
);

    occ_state_e                  state;
    logic                        ready_q;
    logic                        accept, drain;
    logic                        main_load, main_clear, skid_load, skid_clear, main_from_skid;

    logic                        main_valid, skid_valid;
    logic [NUM_LANES*ADDR_W-1:0] main_waddr, skid_waddr, main_d_waddr;
    logic [NUM_LANES-1:0]        main_we, skid_we, main_d_we;
    logic [NUM_LANES*DATA_W-1:0] main_wdata, skid_wdata, main_d_wdata;

    assign accept = in_bus.valid & ready_q;
    assign drain  = main_valid & out_bus.ready;

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: main_load = accept;
                OCC_ONE: begin
                    if (accept && drain)  main_load  = 1'b1;
                    else if (accept)      skid_load  = 1'b1;
                    else if (drain)       main_clear = 1'b1;
                end
                OCC_TWO: begin
                    if (drain && skid_valid) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_d_waddr = main_from_skid ? skid_waddr : in_bus.waddr;
    assign main_d_we    = main_from_skid ? skid_we    : in_bus.we;
    assign main_d_wdata = main_from_skid ? skid_wdata : in_bus.wdata;

    // Occupancy FSM; ready_q tracks "skid slot free" one cycle ahead so that
    // in_bus.ready never depends combinationally on out_bus.ready.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state   <= OCC_EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) state <= OCC_ONE;
                OCC_ONE: begin
                    if (accept && !drain) begin
                        state   <= OCC_TWO;
                        ready_q <= 1'b0;
                    end else if (!accept && drain) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (drain) begin
                        state   <= OCC_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= OCC_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (main_valid && !out_bus.ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    pipe_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LANES(NUM_LANES)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .d_waddr (main_d_waddr),
        .d_we    (main_d_we),
        .d_wdata (main_d_wdata),
        .valid   (main_valid),
        .q_waddr (main_waddr),
        .q_we    (main_we),
        .q_wdata (main_wdata)
    );

    pipe_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LANES(NUM_LANES)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_waddr (in_bus.waddr),
        .d_we    (in_bus.we),
        .d_wdata (in_bus.wdata),
        .valid   (skid_valid),
        .q_waddr (skid_waddr),
        .q_we    (skid_we),
        .q_wdata (skid_wdata)
    );

    assign in_bus.ready  = ready_q;
    assign out_bus.valid = main_valid;
    assign out_bus.waddr = main_waddr;
    assign out_bus.we    = main_we & {NUM_LANES{main_valid}};
    assign out_bus.wdata = main_wdata;

endmodule
